// File: rtl/eth_sfd_detect_if.sv
// Payload beat stream from the SFD detector to the frame receiver.
// Single-cycle beats qualified by vld; the consumer answers with ready.
interface eth_sfd_detect_if;
    logic [7:0] data;
    logic       start;
    logic       vld;
    logic       eop;
    logic       err;
    logic       ready;

    modport master (
        output data, start, vld, eop, err,
        input  ready
    );

    modport slave (
        input  data, start, vld, eop, err,
        output ready
    );
endinterface

// File: rtl/eth_sfd_detect.sv
// Ethernet receive front-end: locks onto the 0x55 preamble and 0xD5 SFD,
// strips both, and forwards payload bytes as framed beats. The PHY cannot be
// stalled, so refused beats are lost and the frame is flagged bad.
module eth_sfd_detect #(
    parameter int MIN_PREAMBLE = 7,
    parameter int MAX_FRAME    = 1518,
    parameter int CNT_W        = 11
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [7:0]               rxd,
    input  logic                     rx_dv,
    input  logic                     rx_er,
    eth_sfd_detect_if.master         rx_out
);

    localparam int PRE_W = (MIN_PREAMBLE < 2) ? 1 : $clog2(MIN_PREAMBLE + 1);

    typedef enum logic [1:0] {
        IDLE,
        PRE,
        PAY,
        DROP
    } state_t;

    state_t           state_q, state_d;
    logic [PRE_W-1:0] pre_cnt_q, pre_cnt_d;
    logic [CNT_W-1:0] byte_cnt_q, byte_cnt_d;
    logic [7:0]       hold_q, hold_d;
    logic             err_f_q, err_f_d;
    logic             ovr_f_q, ovr_f_d;
    logic [7:0]       data_q, data_d;
    logic             start_q, start_d;
    logic             vld_q, vld_d;
    logic             eop_q, eop_d;
    logic             err_q, err_d;
    logic             ovr_now;

    assign ovr_now = vld_q & ~rx_out.ready;

    // State, counters, hold byte, sticky flags and the registered output beat.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            pre_cnt_q  <= '0;
            byte_cnt_q <= '0;
            hold_q     <= '0;
            err_f_q    <= 1'b0;
            ovr_f_q    <= 1'b0;
            data_q     <= '0;
            start_q    <= 1'b0;
            vld_q      <= 1'b0;
            eop_q      <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            pre_cnt_q  <= pre_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            hold_q     <= hold_d;
            err_f_q    <= err_f_d;
            ovr_f_q    <= ovr_f_d;
            data_q     <= data_d;
            start_q    <= start_d;
            vld_q      <= vld_d;
            eop_q      <= eop_d;
            err_q      <= err_d;
        end
    end

    // Next-state logic; a held byte is emitted only once its successor is seen.
    always_comb begin
        state_d    = state_q;
        pre_cnt_d  = pre_cnt_q;
        byte_cnt_d = byte_cnt_q;
        hold_d     = hold_q;
        err_f_d    = err_f_q;
        // A beat refused this cycle is already lost; fold it into the flag now
        // so an eop beat produced on the same edge reports it.
        ovr_f_d    = ovr_f_q | ovr_now;
        data_d     = '0;
        start_d    = 1'b0;
        vld_d      = 1'b0;
        eop_d      = 1'b0;
        err_d      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (rx_dv) begin
                    if (!rx_er && rxd == 8'h55) begin
                        state_d   = PRE;
                        pre_cnt_d = PRE_W'(1);
                    end else begin
                        state_d = DROP;
                    end
                end
            end

            PRE: begin
                if (!rx_dv) begin
                    state_d = IDLE;
                end else if (rx_er) begin
                    state_d = DROP;
                end else if (rxd == 8'h55) begin
                    if (pre_cnt_q < PRE_W'(MIN_PREAMBLE)) begin
                        pre_cnt_d = pre_cnt_q + PRE_W'(1);
                    end
                end else if (rxd == 8'hD5 && pre_cnt_q >= PRE_W'(MIN_PREAMBLE)) begin
                    state_d    = PAY;
                    byte_cnt_d = '0;
                    err_f_d    = 1'b0;
                    ovr_f_d    = 1'b0;
                end else begin
                    state_d = DROP;
                end
            end

            PAY: begin
                if (rx_dv) begin
                    if (byte_cnt_q == CNT_W'(MAX_FRAME)) begin
                        // Frame too long: close it on the held byte, discard the rest.
                        vld_d      = 1'b1;
                        data_d     = hold_q;
                        start_d    = (byte_cnt_q == CNT_W'(1));
                        eop_d      = 1'b1;
                        err_d      = 1'b1;
                        byte_cnt_d = CNT_W'(MAX_FRAME + 1);
                        state_d    = DROP;
                    end else begin
                        if (byte_cnt_q != '0) begin
                            vld_d   = 1'b1;
                            data_d  = hold_q;
                            start_d = (byte_cnt_q == CNT_W'(1));
                        end
                        hold_d     = rxd;
                        byte_cnt_d = byte_cnt_q + CNT_W'(1);
                        if (rx_er) begin
                            err_f_d = 1'b1;
                        end
                    end
                end else begin
                    if (byte_cnt_q != '0) begin
                        vld_d   = 1'b1;
                        data_d  = hold_q;
                        start_d = (byte_cnt_q == CNT_W'(1));
                        eop_d   = 1'b1;
                        err_d   = err_f_q | ovr_f_d;
                    end
                    state_d = IDLE;
                end
            end

            DROP: begin
                if (!rx_dv) begin
                    state_d = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    assign rx_out.data  = data_q;
    assign rx_out.start = start_q;
    assign rx_out.vld   = vld_q;
    assign rx_out.eop   = eop_q;
    assign rx_out.err   = err_q;

endmodule

// File: tb/tb_eth_sfd_detect.sv
// Directed bench for eth_sfd_detect, built with MAX_FRAME=4 so truncation is
// reachable with short frames.
module tb_eth_sfd_detect;

    typedef struct packed {
        logic [7:0] d;
        logic       s;
        logic       e;
        logic       r;
    } beat_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] rxd = 8'h00;
    logic       rx_dv = 1'b0;
    logic       rx_er = 1'b0;

    int errors = 0;
    int checks = 0;
    int vld_cnt = 0;
    beat_t q[$];

    eth_sfd_detect_if bus ();

    eth_sfd_detect #(
        .MIN_PREAMBLE (7),
        .MAX_FRAME    (4),
        .CNT_W        (11)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .rxd    (rxd),
        .rx_dv  (rx_dv),
        .rx_er  (rx_er),
        .rx_out (bus)
    );

    always #5 clk = ~clk;

    // Collect beats accepted by the consumer; count every vld cycle.
    always @(negedge clk) begin
        if (bus.vld === 1'b1) begin
            vld_cnt++;
            if (bus.ready === 1'b1) begin
                q.push_back({bus.data, bus.start, bus.eop, bus.err});
            end
        end
    end

    task automatic drive(input logic [7:0] b, input logic dv, input logic er);
        rxd   = b;
        rx_dv = dv;
        rx_er = er;
        @(posedge clk);
        #1;
    endtask

    task automatic preamble_sfd(input int n);
        for (int i = 0; i < n; i++) drive(8'h55, 1'b1, 1'b0);
        drive(8'hD5, 1'b1, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(8'h00, 1'b0, 1'b0);
    endtask

    task automatic test_reset;
        logic [11:0] got;
        #2;
        got = {bus.vld, bus.start, bus.eop, bus.err, bus.data};
        checks++;
        if (got !== 12'h000) begin
            errors++;
            $display("FAIL reset_outputs got=%h want=000", got);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        idle(2);
        checks++;
        if (vld_cnt != 0) begin
            errors++;
            $display("FAIL reset_idle_vld got=%0d want=0", vld_cnt);
        end
    endtask

    task automatic test_basic;
        beat_t exp[3] = '{{8'h01, 3'b100}, {8'h02, 3'b000}, {8'h03, 3'b010}};
        beat_t got;
        q.delete();
        preamble_sfd(7);
        drive(8'h01, 1'b1, 1'b0);
        drive(8'h02, 1'b1, 1'b0);
        drive(8'h03, 1'b1, 1'b0);
        idle(4);
        checks++;
        if (q.size() != 3) begin
            errors++;
            $display("FAIL basic_count got=%0d want=3", q.size());
        end
        for (int i = 0; i < 3; i++) begin
            got = (i < q.size()) ? q[i] : 'x;
            checks++;
            if (got !== exp[i]) begin
                errors++;
                $display("FAIL basic_beat%0d got d=%h s=%b e=%b r=%b want d=%h s=%b e=%b r=%b",
                         i, got.d, got.s, got.e, got.r, exp[i].d, exp[i].s, exp[i].e, exp[i].r);
            end
        end
    endtask

    task automatic test_short_preamble;
        int base;
        beat_t got;
        q.delete();
        base = vld_cnt;
        preamble_sfd(5);
        for (int i = 0; i < 4; i++) drive(8'h10 + 8'(i), 1'b1, 1'b0);
        idle(3);
        checks++;
        if (vld_cnt != base) begin
            errors++;
            $display("FAIL short_pre_vld got=%0d want=0", vld_cnt - base);
        end
        // Zero-byte frame: SFD followed directly by rx_dv low.
        preamble_sfd(7);
        idle(3);
        checks++;
        if (vld_cnt != base) begin
            errors++;
            $display("FAIL zero_byte_vld got=%0d want=0", vld_cnt - base);
        end
        preamble_sfd(7);
        drive(8'hAA, 1'b1, 1'b0);
        idle(3);
        got = (q.size() > 0) ? q[0] : 'x;
        checks++;
        if (q.size() != 1 || got !== {8'hAA, 3'b110}) begin
            errors++;
            $display("FAIL short_pre_next got n=%0d d=%h s=%b e=%b r=%b want n=1 d=aa s=1 e=1 r=0",
                     q.size(), got.d, got.s, got.e, got.r);
        end
    endtask

    task automatic test_rx_er;
        beat_t exp[3] = '{{8'h11, 3'b100}, {8'h22, 3'b000}, {8'h33, 3'b011}};
        beat_t got;
        q.delete();
        preamble_sfd(7);
        drive(8'h11, 1'b1, 1'b0);
        drive(8'h22, 1'b1, 1'b1);
        drive(8'h33, 1'b1, 1'b0);
        idle(4);
        checks++;
        if (q.size() != 3) begin
            errors++;
            $display("FAIL rx_er_count got=%0d want=3", q.size());
        end
        for (int i = 0; i < 3; i++) begin
            got = (i < q.size()) ? q[i] : 'x;
            checks++;
            if (got !== exp[i]) begin
                errors++;
                $display("FAIL rx_er_beat%0d got d=%h s=%b e=%b r=%b want d=%h s=%b e=%b r=%b",
                         i, got.d, got.s, got.e, got.r, exp[i].d, exp[i].s, exp[i].e, exp[i].r);
            end
        end
    endtask

    task automatic test_truncation;
        beat_t exp[4] = '{{8'hA1, 3'b100}, {8'hA2, 3'b000}, {8'hA3, 3'b000}, {8'hA4, 3'b011}};
        beat_t ex2[4] = '{{8'hB1, 3'b100}, {8'hB2, 3'b000}, {8'hB3, 3'b000}, {8'hB4, 3'b010}};
        beat_t got;
        q.delete();
        preamble_sfd(7);
        for (int i = 1; i <= 6; i++) drive(8'hA0 + 8'(i), 1'b1, 1'b0);
        idle(4);
        checks++;
        if (q.size() != 4) begin
            errors++;
            $display("FAIL trunc_count got=%0d want=4", q.size());
        end
        for (int i = 0; i < 4; i++) begin
            got = (i < q.size()) ? q[i] : 'x;
            checks++;
            if (got !== exp[i]) begin
                errors++;
                $display("FAIL trunc_beat%0d got d=%h s=%b e=%b r=%b want d=%h s=%b e=%b r=%b",
                         i, got.d, got.s, got.e, got.r, exp[i].d, exp[i].s, exp[i].e, exp[i].r);
            end
        end
        // Exactly MAX_FRAME bytes is a legal frame.
        q.delete();
        preamble_sfd(7);
        for (int i = 1; i <= 4; i++) drive(8'hB0 + 8'(i), 1'b1, 1'b0);
        idle(4);
        checks++;
        if (q.size() != 4) begin
            errors++;
            $display("FAIL max_len_count got=%0d want=4", q.size());
        end
        for (int i = 0; i < 4; i++) begin
            got = (i < q.size()) ? q[i] : 'x;
            checks++;
            if (got !== ex2[i]) begin
                errors++;
                $display("FAIL max_len_beat%0d got d=%h s=%b e=%b r=%b want d=%h s=%b e=%b r=%b",
                         i, got.d, got.s, got.e, got.r, ex2[i].d, ex2[i].s, ex2[i].e, ex2[i].r);
            end
        end
    endtask

    task automatic test_overrun;
        beat_t exp[2] = '{{8'h01, 3'b100}, {8'h03, 3'b011}};
        beat_t got;
        int base;
        q.delete();
        base = vld_cnt;
        preamble_sfd(7);
        drive(8'h01, 1'b1, 1'b0);
        drive(8'h02, 1'b1, 1'b0);
        drive(8'h03, 1'b1, 1'b0);
        bus.ready = 1'b0;
        drive(8'h00, 1'b0, 1'b0);
        bus.ready = 1'b1;
        idle(3);
        checks++;
        if (q.size() != 2 || vld_cnt - base != 3) begin
            errors++;
            $display("FAIL overrun_count got=%0d/%0d want=2/3", q.size(), vld_cnt - base);
        end
        for (int i = 0; i < 2; i++) begin
            got = (i < q.size()) ? q[i] : 'x;
            checks++;
            if (got !== exp[i]) begin
                errors++;
                $display("FAIL overrun_beat%0d got d=%h s=%b e=%b r=%b want d=%h s=%b e=%b r=%b",
                         i, got.d, got.s, got.e, got.r, exp[i].d, exp[i].s, exp[i].e, exp[i].r);
            end
        end
    endtask

    task automatic test_back_to_back;
        beat_t exp[3] = '{{8'h5A, 3'b110}, {8'hC1, 3'b100}, {8'hC2, 3'b010}};
        beat_t got;
        q.delete();
        preamble_sfd(7);
        drive(8'h5A, 1'b1, 1'b0);
        idle(1);
        preamble_sfd(7);
        drive(8'hC1, 1'b1, 1'b0);
        drive(8'hC2, 1'b1, 1'b0);
        idle(4);
        checks++;
        if (q.size() != 3) begin
            errors++;
            $display("FAIL b2b_count got=%0d want=3", q.size());
        end
        for (int i = 0; i < 3; i++) begin
            got = (i < q.size()) ? q[i] : 'x;
            checks++;
            if (got !== exp[i]) begin
                errors++;
                $display("FAIL b2b_beat%0d got d=%h s=%b e=%b r=%b want d=%h s=%b e=%b r=%b",
                         i, got.d, got.s, got.e, got.r, exp[i].d, exp[i].s, exp[i].e, exp[i].r);
            end
        end
    endtask

    task automatic test_reset_mid;
        logic [11:0] outs;
        beat_t got;
        q.delete();
        preamble_sfd(7);
        drive(8'h01, 1'b1, 1'b0);
        drive(8'h02, 1'b1, 1'b0);
        drive(8'h03, 1'b1, 1'b0);
        rst = 1'b0;
        #1;
        outs = {bus.vld, bus.start, bus.eop, bus.err, bus.data};
        checks++;
        if (outs !== 12'h000) begin
            errors++;
            $display("FAIL reset_mid_outputs got=%h want=000", outs);
        end
        rx_dv = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        idle(4);
        got = (q.size() > 0) ? q[0] : 'x;
        checks++;
        if (q.size() != 1 || got !== {8'h01, 3'b100}) begin
            errors++;
            $display("FAIL reset_mid_beats got n=%0d d=%h s=%b e=%b r=%b want n=1 d=01 s=1 e=0 r=0",
                     q.size(), got.d, got.s, got.e, got.r);
        end
    endtask

    initial begin
        bus.ready = 1'b1;
        test_reset;
        test_basic;
        test_short_preamble;
        test_rx_er;
        test_truncation;
        test_overrun;
        test_back_to_back;
        test_reset_mid;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
